// File: rtl/keypad_scan_pkg.sv
// Shared types, constants and helpers for the 4x4 keypad scanner.
package keypad_scan_pkg;

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HELD     = 2'd2
  } state_e;

  localparam logic [3:0] KEY_CLEAR = 4'hC;
  localparam logic [3:0] ROW_RESET = 4'b1110;

  // Key codes indexed by {row_idx, col_idx}; entry 0 is row 0 / column 0.
  localparam logic [15:0][3:0] KEY_MAP = {
    4'hD, 4'hF, 4'h0, 4'hE,   // row 3: c3..c0
    4'hC, 4'h9, 4'h8, 4'h7,   // row 2
    4'hB, 4'h6, 4'h5, 4'h4,   // row 1
    4'hA, 4'h3, 4'h2, 4'h1    // row 0
  };

  // Index of the single low bit of a one-hot active-low row drive.
  function automatic logic [1:0] row_index(input logic [3:0] row);
    logic [1:0] idx;
    idx = 2'd0;
    case (row)
      4'b1101: idx = 2'd1;
      4'b1011: idx = 2'd2;
      4'b0111: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

  // Lowest-indexed low column wins when several are low.
  function automatic logic [1:0] col_select(input logic [3:0] col);
    logic [1:0] idx;
    idx = 2'd3;
    if (!col[0])      idx = 2'd0;
    else if (!col[1]) idx = 2'd1;
    else if (!col[2]) idx = 2'd2;
    return idx;
  endfunction

  // Advance the active-low row one position: 1110 -> 1101 -> 1011 -> 0111.
  function automatic logic [3:0] row_rotate(input logic [3:0] row);
    return {row[2:0], row[3]};
  endfunction

endpackage

// File: rtl/keypad_debounce_fsm.sv
// Scan tick generation, row drive and press/release debounce state machine.
module keypad_debounce_fsm
  import keypad_scan_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 50000,
  parameter int unsigned DEB_CNT  = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       col_hit,
  input  logic [1:0] col_idx,
  input  logic [3:0] code_in,
  output logic [3:0] row_out,
  output logic [3:0] key_code_out,
  output logic       key_valid_out,
  output logic       key_down_out
);

  localparam int unsigned CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned DW = $clog2(DEB_CNT + 1);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] deb_q, deb_d;
  logic [DW-1:0] rel_q, rel_d;
  logic [DW-1:0] deb_inc, rel_inc;
  logic [3:0]    row_q, row_d;
  logic [1:0]    cand_col_q, cand_col_d;
  logic [3:0]    cand_code_q, cand_code_d;
  logic [3:0]    key_code_q, key_code_d;
  logic          key_valid_q, key_valid_d;
  logic          key_down_q, key_down_d;
  logic          tick_c;

  // Next-state logic: everything advances only on a scan tick; the row stays
  // put through DEBOUNCE/HELD, so the candidate row is implied by row_q.
  always_comb begin
    tick_c      = (cnt_q == CW'(SCAN_DIV - 1));
    cnt_d       = tick_c ? '0 : cnt_q + CW'(1);
    deb_inc     = deb_q + DW'(1);
    rel_inc     = rel_q + DW'(1);
    state_d     = state_q;
    deb_d       = deb_q;
    rel_d       = rel_q;
    row_d       = row_q;
    cand_col_d  = cand_col_q;
    cand_code_d = cand_code_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    key_down_d  = key_down_q;

    if (tick_c) begin
      case (state_q)
        ST_SCAN: begin
          if (col_hit) begin
            state_d     = ST_DEBOUNCE;
            cand_col_d  = col_idx;
            cand_code_d = code_in;
            deb_d       = '0;
          end else begin
            row_d = row_rotate(row_q);
          end
        end
        ST_DEBOUNCE: begin
          if (col_hit && (col_idx == cand_col_q)) begin
            if (deb_inc == DW'(DEB_CNT)) begin
              state_d     = ST_HELD;
              key_code_d  = cand_code_q;
              key_valid_d = 1'b1;
              key_down_d  = 1'b1;
              deb_d       = '0;
              rel_d       = '0;
            end else begin
              deb_d = deb_inc;
            end
          end else begin
            state_d = ST_SCAN;
            deb_d   = '0;
            row_d   = row_rotate(row_q);
          end
        end
        ST_HELD: begin
          if (col_hit) begin
            rel_d = '0;
          end else if (rel_inc == DW'(DEB_CNT)) begin
            state_d    = ST_SCAN;
            key_down_d = 1'b0;
            rel_d      = '0;
            row_d      = row_rotate(row_q);
          end else begin
            rel_d = rel_inc;
          end
        end
        default: begin
          state_d = ST_SCAN;
          row_d   = ROW_RESET;
        end
      endcase
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_SCAN;
      cnt_q       <= '0;
      deb_q       <= '0;
      rel_q       <= '0;
      row_q       <= ROW_RESET;
      cand_col_q  <= 2'd0;
      cand_code_q <= 4'd0;
      key_code_q  <= 4'd0;
      key_valid_q <= 1'b0;
      key_down_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      deb_q       <= deb_d;
      rel_q       <= rel_d;
      row_q       <= row_d;
      cand_col_q  <= cand_col_d;
      cand_code_q <= cand_code_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_down_q  <= key_down_d;
    end
  end

  assign row_out       = row_q;
  assign key_code_out  = key_code_q;
  assign key_valid_out = key_valid_q;
  assign key_down_out  = key_down_q;

endmodule

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner with debounce and a 4-digit BCD entry buffer.
module keypad_scan
  import keypad_scan_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 50000,
  parameter int unsigned DEB_CNT  = 20
) (
  input  logic       clk,
  input  logic       rst,
  output logic [3:0] ROW,
  input  logic [3:0] COL,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_down,
  output logic [3:0] BCD3,
  output logic [3:0] BCD2,
  output logic [3:0] BCD1,
  output logic [3:0] BCD0
);

  logic [3:0]      col_s1_q, col_s1_d;
  logic [3:0]      col_s2_q, col_s2_d;
  logic [3:0][3:0] bcd_q, bcd_d;
  logic [3:0]      row_w;
  logic [3:0]      key_code_w;
  logic            key_valid_w;
  logic            key_down_w;
  logic            col_hit_c;
  logic [1:0]      col_idx_c;
  logic [1:0]      row_idx_c;
  logic [3:0]      code_c;

  // Column synchronizer input and key-map lookup for the driven row.
  always_comb begin
    col_s1_d  = COL;
    col_s2_d  = col_s1_q;
    col_hit_c = (col_s2_q != 4'hF);
    col_idx_c = col_select(col_s2_q);
    row_idx_c = row_index(row_w);
    code_c    = KEY_MAP[{row_idx_c, col_idx_c}];
  end

  // Entry buffer: digits shift in at BCD0, the clear key empties it.
  always_comb begin
    bcd_d = bcd_q;
    if (key_valid_w) begin
      if (key_code_w <= 4'd9) begin
        bcd_d = {bcd_q[2], bcd_q[1], bcd_q[0], key_code_w};
      end else if (key_code_w == KEY_CLEAR) begin
        bcd_d = '0;
      end
    end
  end

  // Synchronizer and buffer registers; idle columns read as pulled-up.
  always_ff @(posedge clk) begin
    if (rst) begin
      col_s1_q <= 4'hF;
      col_s2_q <= 4'hF;
      bcd_q    <= '0;
    end else begin
      col_s1_q <= col_s1_d;
      col_s2_q <= col_s2_d;
      bcd_q    <= bcd_d;
    end
  end

  keypad_debounce_fsm #(
    .SCAN_DIV (SCAN_DIV),
    .DEB_CNT  (DEB_CNT)
  ) u_fsm (
    .clk           (clk),
    .rst           (rst),
    .col_hit       (col_hit_c),
    .col_idx       (col_idx_c),
    .code_in       (code_c),
    .row_out       (row_w),
    .key_code_out  (key_code_w),
    .key_valid_out (key_valid_w),
    .key_down_out  (key_down_w)
  );

  assign ROW       = row_w;
  assign key_code  = key_code_w;
  assign key_valid = key_valid_w;
  assign key_down  = key_down_w;
  assign BCD3      = bcd_q[3];
  assign BCD2      = bcd_q[2];
  assign BCD1      = bcd_q[1];
  assign BCD0      = bcd_q[0];

endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan with a shorting keypad model.
module tb_keypad_scan;

  logic        clk;
  logic        rst;
  logic [3:0]  row_w;
  logic [3:0]  col_w;
  logic [3:0]  key_code_w;
  logic        key_valid_w;
  logic        key_down_w;
  logic [3:0]  bcd3_w, bcd2_w, bcd1_w, bcd0_w;
  logic [15:0] keys;
  int          n_cmp;
  int          n_err;
  int          n_valid;

  keypad_scan #(
    .SCAN_DIV (4),
    .DEB_CNT  (3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ROW       (row_w),
    .COL       (col_w),
    .key_code  (key_code_w),
    .key_valid (key_valid_w),
    .key_down  (key_down_w),
    .BCD3      (bcd3_w),
    .BCD2      (bcd2_w),
    .BCD1      (bcd1_w),
    .BCD0      (bcd0_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pressed key at (r,c) pulls column c low while row r is driven low.
  always_comb begin
    col_w = 4'hF;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        if (keys[r*4 + c] && !row_w[r]) col_w[c] = 1'b0;
      end
    end
  end

  // Count cycles with key_valid high (pre-edge value).
  always @(posedge clk) begin
    if (key_valid_w === 1'b1) n_valid++;
  end

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Wait for the negedge right after ROW switches to target (tick phase 0).
  task automatic wait_row_entry(input logic [3:0] target);
    logic [3:0] prev;
    bit seen;
    prev = row_w;
    seen = 1'b0;
    for (int i = 0; i < 64 && !seen; i++) begin
      @(negedge clk);
      if (row_w == target && prev != target) seen = 1'b1;
      prev = row_w;
    end
    chk("row_entry", 16'(seen), 16'd1);
  endtask

  // Clean press: pulse expected exactly 16 clk after row entry; release
  // drops key_down between 9 and 14 clk after the key opens.
  task automatic press_key(input int r, input int c, input logic [3:0] code, input int hold);
    logic [3:0] rp;
    int v0;
    rp = 4'hF;
    rp[r[1:0]] = 1'b0;
    wait_row_entry(rp);
    v0 = n_valid;
    keys[4'(r*4 + c)] = 1'b1;
    repeat (15) @(negedge clk);
    chk("valid_early", 16'(key_valid_w), 16'd0);
    @(negedge clk);
    chk("valid_pulse", 16'(key_valid_w), 16'd1);
    chk("key_code", 16'(key_code_w), 16'(code));
    @(negedge clk);
    chk("valid_width", 16'(key_valid_w), 16'd0);
    chk("down_held", 16'(key_down_w), 16'd1);
    repeat (hold - 17) @(negedge clk);
    keys[4'(r*4 + c)] = 1'b0;
    repeat (8) @(negedge clk);
    chk("down_release_early", 16'(key_down_w), 16'd1);
    repeat (7) @(negedge clk);
    chk("down_release", 16'(key_down_w), 16'd0);
    chk("valid_count", 16'(n_valid - v0), 16'd1);
  endtask

  logic [3:0] row_exp [5];
  int         v0;

  initial begin
    n_cmp   = 0;
    n_err   = 0;
    n_valid = 0;
    keys    = '0;
    rst     = 1'b1;
    row_exp = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset values and idle rotation.
    chk("rst_code", 16'(key_code_w), 16'd0);
    chk("rst_down", 16'(key_down_w), 16'd0);
    chk("rst_bcd", {bcd3_w, bcd2_w, bcd1_w, bcd0_w}, 16'h0000);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("idle_row%0d", i), 16'(row_w), 16'(row_exp[i]));
      repeat (3) @(negedge clk);
      if (i < 4) chk($sformatf("idle_hold%0d", i), 16'(row_w), 16'(row_exp[i]));
      @(negedge clk);
    end
    chk("idle_no_valid", 16'(n_valid), 16'd0);
    chk("idle_bcd", {bcd3_w, bcd2_w, bcd1_w, bcd0_w}, 16'h0000);

    // Key 5 held 40 clk.
    press_key(1, 1, 4'h5, 40);
    chk("bcd_after5", {bcd3_w, bcd2_w, bcd1_w, bcd0_w}, 16'h0005);

    // Digit entry and buffer shift.
    press_key(0, 0, 4'h1, 24);
    press_key(0, 1, 4'h2, 24);
    press_key(0, 2, 4'h3, 24);
    press_key(1, 0, 4'h4, 24);
    chk("bcd_1234", {bcd3_w, bcd2_w, bcd1_w, bcd0_w}, 16'h1234);
    press_key(2, 0, 4'h7, 24);
    chk("bcd_2347", {bcd3_w, bcd2_w, bcd1_w, bcd0_w}, 16'h2347);
    press_key(2, 3, 4'hC, 24);
    chk("bcd_clear", {bcd3_w, bcd2_w, bcd1_w, bcd0_w}, 16'h0000);
    chk("code_clear", 16'(key_code_w), 16'h000C);

    // Short press of 8: aborts debounce, rotation resumes.
    wait_row_entry(4'b1011);
    v0 = n_valid;
    keys[9] = 1'b1;
    repeat (8) @(negedge clk);
    keys[9] = 1'b0;
    @(negedge clk);
    chk("bounce_row_held", 16'(row_w), 16'b1011);
    repeat (4) @(negedge clk);
    chk("bounce_row_next", 16'(row_w), 16'b0111);
    repeat (4) @(negedge clk);
    chk("bounce_row_wrap", 16'(row_w), 16'b1110);
    repeat (10) @(negedge clk);
    chk("bounce_no_valid", 16'(n_valid - v0), 16'd0);
    chk("bounce_down", 16'(key_down_w), 16'd0);

    // Key A with a one-tick release glitch and key 6 pressed meanwhile.
    wait_row_entry(4'b1110);
    v0 = n_valid;
    keys[3] = 1'b1;
    repeat (16) @(negedge clk);
    chk("a_valid", 16'(key_valid_w), 16'd1);
    chk("a_code", 16'(key_code_w), 16'h000A);
    repeat (8) @(negedge clk);
    keys[3] = 1'b0;
    repeat (4) @(negedge clk);
    keys[3] = 1'b1;
    repeat (4) @(negedge clk);
    chk("a_glitch_down", 16'(key_down_w), 16'd1);
    keys[6] = 1'b1;
    repeat (16) @(negedge clk);
    chk("a_with6_down", 16'(key_down_w), 16'd1);
    chk("a_with6_code", 16'(key_code_w), 16'h000A);
    keys[6] = 1'b0;
    repeat (4) @(negedge clk);
    keys[3] = 1'b0;
    repeat (8) @(negedge clk);
    chk("a_rel_early", 16'(key_down_w), 16'd1);
    repeat (7) @(negedge clk);
    chk("a_rel", 16'(key_down_w), 16'd0);
    chk("a_single_valid", 16'(n_valid - v0), 16'd1);
    chk("a_bcd", {bcd3_w, bcd2_w, bcd1_w, bcd0_w}, 16'h0000);

    // Reset during debounce of 9.
    press_key(2, 0, 4'h7, 24);
    chk("bcd_7", {bcd3_w, bcd2_w, bcd1_w, bcd0_w}, 16'h0007);
    wait_row_entry(4'b1011);
    v0 = n_valid;
    keys[10] = 1'b1;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    keys[10] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_row", 16'(row_w), 16'b1110);
    chk("mid_rst_code", 16'(key_code_w), 16'd0);
    chk("mid_rst_valid", 16'(key_valid_w), 16'd0);
    chk("mid_rst_down", 16'(key_down_w), 16'd0);
    chk("mid_rst_bcd", {bcd3_w, bcd2_w, bcd1_w, bcd0_w}, 16'h0000);
    repeat (30) @(negedge clk);
    chk("mid_rst_no_valid", 16'(n_valid - v0), 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
